// File: rtl/fsm_pkg.sv
// Shared types and encodings for the RV32I multi-cycle control sequencer.
// Opcodes match instr[6:0]; the select encodings match the datapath muxes.
package fsm_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMREAD,
    MEMWB,
    MEMWRITE,
    EXECR,
    ALUWB,
    EXECI,
    JAL,
    BEQ,
    ILLEGAL
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/instret_counter.sv
// Retired-instruction counter: increments on en, wraps modulo 2^CNT_W,
// cleared asynchronously by reset_n.
module instret_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/main_fsm.sv
// Multi-cycle control sequencer for the RV32I core: Moore decode of datapath
// selects/strobes, memory-ready handshake, sticky illegal halt, instret.
module main_fsm
  import fsm_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [6:0]       op,
  input  logic             mem_ready,
  output logic             pc_update,
  output logic             branch,
  output logic             ir_write,
  output logic             reg_write,
  output logic             mem_write,
  output logic             adr_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_op,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  state_t state;
  state_t state_next;

  logic pc_update_raw;
  logic branch_raw;
  logic ir_write_raw;
  logic reg_write_raw;
  logic mem_write_raw;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= FETCH;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every combinational output gets a default first so no path through
  // the case leaves a variable unassigned and infers a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      FETCH:    if (mem_ready) state_next = DECODE;
      DECODE: begin
        unique case (op)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_R:         state_next = EXECR;
          OP_I:         state_next = EXECI;
          OP_JAL:       state_next = JAL;
          OP_BEQ:       state_next = BEQ;
          default:      state_next = ILLEGAL;
        endcase
      end
      MEMADR: begin
        if (op == OP_LW)      state_next = MEMREAD;
        else if (op == OP_SW) state_next = MEMWRITE;
        else                  state_next = ILLEGAL;
      end
      MEMREAD:  if (mem_ready) state_next = MEMWB;
      MEMWB:    state_next = FETCH;
      MEMWRITE: if (mem_ready) state_next = FETCH;
      EXECR:    state_next = ALUWB;
      EXECI:    state_next = ALUWB;
      ALUWB:    state_next = FETCH;
      JAL:      state_next = ALUWB;
      BEQ:      state_next = FETCH;
      ILLEGAL:  state_next = ILLEGAL;
      default:  state_next = FETCH;
    endcase
  end

  always_comb begin
    pc_update_raw = 1'b0;
    branch_raw    = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    mem_write_raw = 1'b0;
    adr_src       = 1'b0;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_RS2;
    result_src    = RES_ALUOUT;
    alu_op        = ALUOP_ADD;
    illegal       = 1'b0;
    unique case (state)
      FETCH: begin
        alu_src_b     = SRCB_FOUR;
        result_src    = RES_ALURESULT;
        ir_write_raw  = mem_ready;
        pc_update_raw = mem_ready;
      end
      DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
      end
      MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      MEMREAD: adr_src = 1'b1;
      MEMWB: begin
        result_src    = RES_DATA;
        reg_write_raw = 1'b1;
      end
      MEMWRITE: begin
        adr_src       = 1'b1;
        mem_write_raw = 1'b1;
      end
      EXECR: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_FUNCT;
      end
      EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
      end
      ALUWB: reg_write_raw = 1'b1;
      JAL: begin
        alu_src_a     = SRCA_OLDPC;
        alu_src_b     = SRCB_FOUR;
        pc_update_raw = 1'b1;
      end
      BEQ: begin
        alu_src_a  = SRCA_RS1;
        alu_op     = ALUOP_SUB;
        branch_raw = 1'b1;
      end
      ILLEGAL: illegal = 1'b1;
      default: ;
    endcase
  end

  // FETCH strobes follow mem_ready, so they are masked while reset is held.
  assign pc_update = pc_update_raw & reset_n;
  assign branch    = branch_raw    & reset_n;
  assign ir_write  = ir_write_raw  & reset_n;
  assign reg_write = reg_write_raw & reset_n;
  assign mem_write = mem_write_raw & reset_n;

  instret_counter #(
    .CNT_W (CNT_W)
  ) u_instret (
    .clk     (clk),
    .reset_n (reset_n),
    .en      ((state != FETCH) && (state_next == FETCH)),
    .count   (instret)
  );

endmodule

// File: tb/tb_main_fsm.sv
// Directed bench for main_fsm: per-cycle state/output vectors, handshake
// stalls, illegal halt, async reset, and a 4-bit instret wrap instance.
module tb_main_fsm;
  import fsm_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [6:0]  op;
  logic        mem_ready;
  logic        pc_update, branch, ir_write, reg_write, mem_write, adr_src, illegal;
  logic [1:0]  alu_src_a, alu_src_b, result_src, alu_op;
  logic [31:0] instret;

  logic        reset2_n;
  logic [6:0]  op2;
  logic        mr2;
  logic        pcu2, br2, irw2, rw2, mw2, as2, ill2;
  logic [1:0]  sa2, sb2, rs2, ao2;
  logic [3:0]  instret2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  main_fsm #(.CNT_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .op(op), .mem_ready(mem_ready),
    .pc_update(pc_update), .branch(branch), .ir_write(ir_write),
    .reg_write(reg_write), .mem_write(mem_write), .adr_src(adr_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
    .alu_op(alu_op), .illegal(illegal), .instret(instret)
  );

  main_fsm #(.CNT_W(4)) dut4 (
    .clk(clk), .reset_n(reset2_n), .op(op2), .mem_ready(mr2),
    .pc_update(pcu2), .branch(br2), .ir_write(irw2),
    .reg_write(rw2), .mem_write(mw2), .adr_src(as2),
    .alu_src_a(sa2), .alu_src_b(sb2), .result_src(rs2),
    .alu_op(ao2), .illegal(ill2), .instret(instret2)
  );

  // {pc_update,branch,ir_write,reg_write,mem_write,adr_src,a[1:0],b[1:0],res[1:0],aluop[1:0],illegal}
  localparam logic [14:0] E_FETCH0   = 15'b0_0_0_0_0_0_00_10_10_00_0;
  localparam logic [14:0] E_FETCH1   = 15'b1_0_1_0_0_0_00_10_10_00_0;
  localparam logic [14:0] E_DECODE   = 15'b0_0_0_0_0_0_01_01_00_00_0;
  localparam logic [14:0] E_MEMADR   = 15'b0_0_0_0_0_0_10_01_00_00_0;
  localparam logic [14:0] E_MEMREAD  = 15'b0_0_0_0_0_1_00_00_00_00_0;
  localparam logic [14:0] E_MEMWB    = 15'b0_0_0_1_0_0_00_00_01_00_0;
  localparam logic [14:0] E_MEMWRITE = 15'b0_0_0_0_1_1_00_00_00_00_0;
  localparam logic [14:0] E_EXECR    = 15'b0_0_0_0_0_0_10_00_00_10_0;
  localparam logic [14:0] E_EXECI    = 15'b0_0_0_0_0_0_10_01_00_10_0;
  localparam logic [14:0] E_ALUWB    = 15'b0_0_0_1_0_0_00_00_00_00_0;
  localparam logic [14:0] E_JAL      = 15'b1_0_0_0_0_0_01_10_00_00_0;
  localparam logic [14:0] E_BEQ      = 15'b0_1_0_0_0_0_10_00_00_01_0;
  localparam logic [14:0] E_ILLEGAL  = 15'b0_0_0_0_0_0_00_00_00_00_1;

  function automatic logic [14:0] outs();
    return {pc_update, branch, ir_write, reg_write, mem_write, adr_src,
            alu_src_a, alu_src_b, result_src, alu_op, illegal};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs are already set at the falling edge; sample 1 time unit later,
  // then advance to the next falling edge.
  task automatic cyc(input string tag, input state_t es, input logic [14:0] eo);
    #1;
    check({tag, ".state"}, 32'(dut.state), 32'(es));
    check({tag, ".outs"}, 32'(outs()), 32'(eo));
    @(negedge clk);
  endtask

  task automatic idle_check(input string tag, input logic [31:0] exp_cnt);
    mem_ready = 1'b0;
    #1;
    check({tag, ".state"}, 32'(dut.state), 32'(FETCH));
    check({tag, ".outs"}, 32'(outs()), 32'(E_FETCH0));
    check({tag, ".instret"}, instret, exp_cnt);
    @(negedge clk);
  endtask

  initial begin
    reset_n   = 1'b0;
    mem_ready = 1'b1;
    op        = 7'd0;
    reset2_n  = 1'b0;
    op2       = OP_R;
    mr2       = 1'b1;

    // Reset: strobes forced low even with mem_ready high in FETCH
    repeat (2) @(negedge clk);
    #1;
    check("rst.state", 32'(dut.state), 32'(FETCH));
    check("rst.outs", 32'(outs()), 32'(E_FETCH0));
    check("rst.instret", instret, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // lw, 5 cycles
    op = OP_LW; mem_ready = 1'b1;
    cyc("lw.f", FETCH, E_FETCH1);
    cyc("lw.d", DECODE, E_DECODE);
    cyc("lw.a", MEMADR, E_MEMADR);
    cyc("lw.r", MEMREAD, E_MEMREAD);
    cyc("lw.wb", MEMWB, E_MEMWB);
    idle_check("lw.end", 32'd1);

    // sw with 3 stall cycles: mem_write held for 4 cycles
    op = OP_SW; mem_ready = 1'b1;
    cyc("sw.f", FETCH, E_FETCH1);
    mem_ready = 1'b0;
    cyc("sw.d", DECODE, E_DECODE);
    cyc("sw.a", MEMADR, E_MEMADR);
    for (int i = 0; i < 3; i++) cyc("sw.wait", MEMWRITE, E_MEMWRITE);
    mem_ready = 1'b1;
    cyc("sw.w", MEMWRITE, E_MEMWRITE);
    idle_check("sw.end", 32'd2);

    // beq, 3 cycles
    op = OP_BEQ; mem_ready = 1'b1;
    cyc("beq.f", FETCH, E_FETCH1);
    cyc("beq.d", DECODE, E_DECODE);
    cyc("beq.b", BEQ, E_BEQ);
    idle_check("beq.end", 32'd3);

    // jal, 4 cycles
    op = OP_JAL; mem_ready = 1'b1;
    cyc("jal.f", FETCH, E_FETCH1);
    cyc("jal.d", DECODE, E_DECODE);
    cyc("jal.j", JAL, E_JAL);
    cyc("jal.wb", ALUWB, E_ALUWB);
    idle_check("jal.end", 32'd4);

    // R-type with mem_ready dropping outside FETCH (ignored there)
    op = OP_R; mem_ready = 1'b1;
    cyc("r.f", FETCH, E_FETCH1);
    mem_ready = 1'b0;
    cyc("r.d", DECODE, E_DECODE);
    cyc("r.x", EXECR, E_EXECR);
    cyc("r.wb", ALUWB, E_ALUWB);
    idle_check("r.end", 32'd5);

    // I-type
    op = OP_I; mem_ready = 1'b1;
    cyc("i.f", FETCH, E_FETCH1);
    cyc("i.d", DECODE, E_DECODE);
    cyc("i.x", EXECI, E_EXECI);
    cyc("i.wb", ALUWB, E_ALUWB);
    idle_check("i.end", 32'd6);

    // FETCH stall then lw with 2-cycle read stall
    op = OP_LW; mem_ready = 1'b0;
    cyc("lws.f0", FETCH, E_FETCH0);
    mem_ready = 1'b1;
    cyc("lws.f", FETCH, E_FETCH1);
    cyc("lws.d", DECODE, E_DECODE);
    mem_ready = 1'b0;
    cyc("lws.a", MEMADR, E_MEMADR);
    cyc("lws.r0", MEMREAD, E_MEMREAD);
    cyc("lws.r1", MEMREAD, E_MEMREAD);
    mem_ready = 1'b1;
    cyc("lws.r2", MEMREAD, E_MEMREAD);
    cyc("lws.wb", MEMWB, E_MEMWB);
    idle_check("lws.end", 32'd7);

    // Unsupported opcode: absorbing halt
    op = 7'b1111111; mem_ready = 1'b1;
    cyc("ill.f", FETCH, E_FETCH1);
    cyc("ill.d", DECODE, E_DECODE);
    for (int i = 0; i < 20; i++) begin
      op = (i % 2 == 0) ? OP_R : OP_LW;
      mem_ready = i[0];
      cyc("ill.hold", ILLEGAL, E_ILLEGAL);
    end
    #1;
    check("ill.instret", instret, 32'd7);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("ill.rst.state", 32'(dut.state), 32'(FETCH));
    check("ill.rst.illegal", 32'(illegal), 32'd0);
    check("ill.rst.instret", instret, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Async reset while stalled in MEMREAD
    op = OP_LW; mem_ready = 1'b1;
    cyc("mr.f", FETCH, E_FETCH1);
    cyc("mr.d", DECODE, E_DECODE);
    mem_ready = 1'b0;
    cyc("mr.a", MEMADR, E_MEMADR);
    #1;
    check("mr.r.state", 32'(dut.state), 32'(MEMREAD));
    #2;
    reset_n   = 1'b0;
    mem_ready = 1'b1;
    #1;
    check("mr.rst.state", 32'(dut.state), 32'(FETCH));
    check("mr.rst.outs", 32'(outs()), 32'(E_FETCH0));
    @(negedge clk);
    #1;
    check("mr.rst.hold", 32'(outs()), 32'(E_FETCH0));
    check("mr.rst.instret", instret, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    idle_check("mr.end", 32'd0);

    // CNT_W=4 instance: 16 back-to-back R-types wrap instret to 0
    reset2_n = 1'b1;
    repeat (60) @(negedge clk);
    check("wrap.15", 32'(instret2), 32'd15);
    repeat (4) @(negedge clk);
    check("wrap.0", 32'(instret2), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
